llama_layer_acc_requant: RTL and testbench
==========================================

LLAMA_LAYER_ACC_REQUANT -- requirements
Module: llama_layer_acc_requant

Interface
REQ-001 The block SHALL expose parameter PROD_WIDTH, default 63: width of the signed product input.
REQ-002 The block SHALL expose parameter ACC_WIDTH, default 72: width of the signed accumulator.
REQ-003 The block SHALL expose parameter OUT_WIDTH, default 32: width of the signed requantized result.
REQ-004 The block SHALL expose parameter SHIFT_WIDTH, default 6: width of the right-shift amount.
REQ-005 The block SHALL have port ap_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port ap_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port in_data, input, PROD_WIDTH bits: signed product beat from the upstream multiplier.
REQ-008 The block SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-009 The block SHALL have port in_last, input, 1 bit: the current beat ends the dot-product vector.
REQ-010 The block SHALL have port in_ready, output, 1 bit: the block accepts a beat this cycle.
REQ-011 The block SHALL have port shift, input, SHIFT_WIDTH bits: unsigned arithmetic right-shift amount.
REQ-012 The block SHALL have port out_data, output, OUT_WIDTH bits: signed rounded and saturated result.
REQ-013 The block SHALL have port out_sat, output, 1 bit: out_data was clipped by saturation.
REQ-014 The block SHALL have port out_valid, output, 1 bit: out_data and out_sat are valid.
REQ-015 The block SHALL have port out_ready, input, 1 bit: downstream accepts the result.

Function
REQ-016 A beat SHALL transfer only in a cycle where in_valid=1 and in_ready=1; a result SHALL transfer only in a cycle where out_valid=1 and out_ready=1.
REQ-017 The FSM SHALL have three states, ACC, ROUND and OUT, with reset state ACC.
- ACC: in_ready=1, out_valid=0.
- ROUND: in_ready=0, out_valid=0.
- OUT: in_ready=0, out_valid=1.
REQ-018 In ACC, each accepted beat SHALL update the accumulator as acc <= (first ? 0 : acc) + sign-extended in_data, modulo 2^ACC_WIDTH.
- first=1 on the first beat after reset or after a result transfer.
REQ-019 shift SHALL be sampled on the first beat of each vector and held until that vector's result has transferred.
REQ-020 An accepted beat with in_last=1 SHALL move the FSM from ACC to ROUND; a single-beat vector is legal.
REQ-021 In ROUND the block SHALL compute r = (acc + (s>0 ? 2^(s-1) : 0)) >>> s (round half toward +infinity, arithmetic shift, s = sampled shift), register the result, and move to OUT.
REQ-022 If r > 2^(OUT_WIDTH-1)-1, out_data SHALL be 2^(OUT_WIDTH-1)-1 with out_sat=1.
REQ-023 If r < -2^(OUT_WIDTH-1), out_data SHALL be -2^(OUT_WIDTH-1) with out_sat=1.
REQ-024 If r is within range, out_data SHALL be r with out_sat=0.
REQ-025 Latency SHALL be fixed: with the last beat accepted in cycle N, out_valid SHALL be 1 in cycle N+2.
REQ-026 In OUT, out_data and out_sat SHALL stay stable while out_ready=0.
REQ-027 A result transfer SHALL return the FSM to ACC with first=1, so in_ready=1 in the following cycle.
- There is no same-cycle bypass.
REQ-028 Overflow of the accumulator modulo 2^ACC_WIDTH SHALL wrap silently.
- Upstream guarantees at most 2^(ACC_WIDTH-PROD_WIDTH) beats per vector.
REQ-029 Beats presented while in_ready=0 SHALL be ignored, and in_data SHALL be left unconsumed.

Reset
REQ-030 Asserting ap_rst_n=0 SHALL set, asynchronously and in any state including mid-vector:
- FSM=ACC, first=1, accumulator=0, sampled shift=0;
- out_data=0, out_sat=0, out_valid=0.
REQ-031 After ap_rst_n is released, in_ready SHALL be 1 from the first clock edge onward.
REQ-032 A partially accumulated vector SHALL be discarded on reset, with no result emitted for it.

Verification
REQ-033 Reset check: hold ap_rst_n=0 for 3 cycles -> out_valid=0, out_data=0, out_sat=0; after release, in_ready=1.
REQ-034 Basic sum: beats 10, 20, -5, 7 (last on 7), shift=0, out_ready=1 -> out_data=32, out_sat=0, out_valid exactly 2 cycles after the last beat.
REQ-035 Rounding:
- single beat 6, shift=2 -> out_data=2;
- single beat -6, shift=2 -> out_data=-1;
- single beat 5, shift=1 -> out_data=3.
REQ-036 Saturation:
- single beat 2^40, shift=0 -> out_data=2147483647, out_sat=1;
- single beat -2^40, shift=0 -> out_data=-2147483648, out_sat=1;
- single beat 2^40, shift=10 -> out_data=2^30, out_sat=0.
REQ-037 Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 -> out_data stable, in_ready=0, no beats consumed; raise out_ready -> one transfer, then in_ready=1 on the next cycle.
REQ-038 Reset mid-vector: accept beats 100, 200 (no last), pulse ap_rst_n=0, then send a single beat 3 with shift=0 -> out_data=3.

Source files
------------

// File: rtl/llama_layer_acc_requant_if.sv
// Stream bundle between the product source, the accumulate/requantize block
// and the result sink.
//
// Handshake: every stream moves one item on a rising ap_clk edge where its
// valid and ready are both 1. A producer holds valid and its payload steady
// until that edge. A consumer may drive ready low at any time. ready never
// depends combinationally on valid.
interface llama_layer_acc_requant_if #(
    parameter int PROD_WIDTH  = 63,
    parameter int OUT_WIDTH   = 32,
    parameter int SHIFT_WIDTH = 6
) ();
    logic [PROD_WIDTH-1:0]  in_data;
    logic                   in_valid;
    logic                   in_last;
    logic                   in_ready;
    logic [SHIFT_WIDTH-1:0] shift;
    logic [OUT_WIDTH-1:0]   out_data;
    logic                   out_sat;
    logic                   out_valid;
    logic                   out_ready;

    // The block being fed sees this view.
    modport slave (
        input  in_data, in_valid, in_last, shift, out_ready,
        output in_ready, out_data, out_sat, out_valid
    );

    // The environment around the block sees this view.
    modport master (
        output in_data, in_valid, in_last, shift, out_ready,
        input  in_ready, out_data, out_sat, out_valid
    );
endinterface

// File: rtl/llama_layer_acc_requant.sv
// Dot-product accumulator with round-half-up requantization and saturation.
// Product beats are summed until in_last. The sum is then shifted right with
// rounding, clipped to OUT_WIDTH, and held on the output until it is taken.
module llama_layer_acc_requant #(
    parameter int PROD_WIDTH  = 63,
    parameter int ACC_WIDTH   = 72,
    parameter int OUT_WIDTH   = 32,
    parameter int SHIFT_WIDTH = 6
) (
    input  logic        ap_clk,
    input  logic        ap_rst_n,
    llama_layer_acc_requant_if.slave bus,
    output logic [1:0]  dbg_state_o
);
    typedef enum logic [1:0] {
        ST_ACC   = 2'd0,
        ST_ROUND = 2'd1,
        ST_OUT   = 2'd2
    } state_t;

    localparam logic signed [ACC_WIDTH:0] ONE     = {{ACC_WIDTH{1'b0}}, 1'b1};
    localparam logic signed [ACC_WIDTH:0] OUT_MAX = (ONE <<< (OUT_WIDTH - 1)) - ONE;
    localparam logic signed [ACC_WIDTH:0] OUT_MIN = ~OUT_MAX;

    state_t                 state_q, state_d;
    logic                   first_q, first_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [SHIFT_WIDTH-1:0] shift_q, shift_d;
    logic [OUT_WIDTH-1:0]   out_data_q, out_data_d;
    logic                   out_sat_q, out_sat_d;
    logic                   in_ready_c, out_valid_c;

    logic [ACC_WIDTH-1:0]      beat_ext;
    logic signed [ACC_WIDTH:0] acc_ext, rnd, sum, r;

    assign beat_ext = {{(ACC_WIDTH - PROD_WIDTH){bus.in_data[PROD_WIDTH-1]}}, bus.in_data};

    // Rounding datapath: one extra bit so adding the half-LSB cannot overflow.
    always_comb begin
        acc_ext = {acc_q[ACC_WIDTH-1], acc_q};
        rnd     = '0;
        if (shift_q != '0) begin
            rnd = ONE <<< (shift_q - 1'b1);
        end
        sum = acc_ext + rnd;
        r   = sum >>> shift_q;
    end

    // Next-state and handshake outputs for the ACC -> ROUND -> OUT cycle.
    always_comb begin
        state_d     = state_q;
        first_d     = first_q;
        acc_d       = acc_q;
        shift_d     = shift_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        case (state_q)
            ST_ACC: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    acc_d   = (first_q ? '0 : acc_q) + beat_ext;
                    first_d = 1'b0;
                    if (first_q) begin
                        shift_d = bus.shift;
                    end
                    if (bus.in_last) begin
                        state_d = ST_ROUND;
                    end
                end
            end
            ST_ROUND: begin
                if (r > OUT_MAX) begin
                    out_data_d = OUT_MAX[OUT_WIDTH-1:0];
                    out_sat_d  = 1'b1;
                end else if (r < OUT_MIN) begin
                    out_data_d = OUT_MIN[OUT_WIDTH-1:0];
                    out_sat_d  = 1'b1;
                end else begin
                    out_data_d = r[OUT_WIDTH-1:0];
                    out_sat_d  = 1'b0;
                end
                state_d = ST_OUT;
            end
            ST_OUT: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) begin
                    first_d = 1'b1;
                    state_d = ST_ACC;
                end
            end
            default: begin
                state_d = ST_ACC;
                first_d = 1'b1;
            end
        endcase
    end

    // State registers; reset drops any partial vector.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q    <= ST_ACC;
            first_q    <= 1'b1;
            acc_q      <= '0;
            shift_q    <= '0;
            out_data_q <= '0;
            out_sat_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            first_q    <= first_d;
            acc_q      <= acc_d;
            shift_q    <= shift_d;
            out_data_q <= out_data_d;
            out_sat_q  <= out_sat_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.out_data  = out_data_q;
    assign bus.out_sat   = out_sat_q;
    assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_llama_layer_acc_requant.sv
// Directed bench for llama_layer_acc_requant with a queue-based scoreboard.
module tb_llama_layer_acc_requant;
  logic ap_clk;
  logic ap_rst_n;
  logic [1:0] dbg_state;
  int cyc;
  int last_cyc;
  int n_cmp;
  int n_err;
  logic prev_valid;
  logic [32:0] exp_q[$];

  llama_layer_acc_requant_if bus ();

  llama_layer_acc_requant dut (
    .ap_clk      (ap_clk),
    .ap_rst_n    (ap_rst_n),
    .bus         (bus.slave),
    .dbg_state_o (dbg_state)
  );

  // clock / reset block
  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;
  always @(posedge ap_clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endfunction

  function automatic void fail_now(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: timed out", name);
  endfunction

  // driver: present one beat and hold it until it transfers
  task automatic send_beat(input logic [62:0] d, input logic last, input logic [5:0] s);
    int budget;
    bus.in_data  = d;
    bus.in_last  = last;
    bus.shift    = s;
    bus.in_valid = 1'b1;
    budget = 0;
    @(negedge ap_clk);
    while (!bus.in_ready && budget < 50) begin
      @(negedge ap_clk);
      budget++;
    end
    if (budget >= 50) fail_now("beat_accept");
    else if (last) last_cyc = cyc;
    @(posedge ap_clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic push_exp(input logic sat, input logic [31:0] d);
    exp_q.push_back({sat, d});
  endtask

  task automatic wait_drain();
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 100) begin
      @(negedge ap_clk);
      budget++;
    end
    if (exp_q.size() != 0) fail_now("drain");
    @(posedge ap_clk);
    #1;
  endtask

  // scoreboard monitor: every presented result must match the queue head
  always @(negedge ap_clk) begin
    if (!ap_rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (bus.out_valid) begin
        if (!prev_valid) check("latency", 64'(cyc - last_cyc), 64'd2);
        if (exp_q.size() == 0) begin
          fail_now("unexpected_result");
        end else begin
          check("result", 64'({bus.out_sat, bus.out_data}), 64'(exp_q[0]));
          if (bus.out_ready) void'(exp_q.pop_front());
        end
      end
      prev_valid = bus.out_valid;
    end
  end

  initial begin
    int budget;
    n_cmp = 0;
    n_err = 0;
    cyc = 0;
    last_cyc = 0;
    prev_valid = 1'b0;
    bus.in_data = '0;
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
    bus.shift = '0;
    bus.out_ready = 1'b1;

    // reset state
    ap_rst_n = 1'b0;
    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_data", 64'(bus.out_data), 64'd0);
    check("rst_out_sat", 64'(bus.out_sat), 64'd0);
    ap_rst_n = 1'b1;
    @(posedge ap_clk);
    @(negedge ap_clk);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge ap_clk);
    #1;

    // basic sum 10+20-5+7
    push_exp(1'b0, 32'd32);
    send_beat(63'd10, 1'b0, 6'd0);
    send_beat(63'd20, 1'b0, 6'd0);
    send_beat(-63'sd5, 1'b0, 6'd0);
    send_beat(63'd7, 1'b1, 6'd0);
    wait_drain();

    // rounding
    push_exp(1'b0, 32'd2);
    send_beat(63'd6, 1'b1, 6'd2);
    wait_drain();
    push_exp(1'b0, 32'hFFFF_FFFF);
    send_beat(-63'sd6, 1'b1, 6'd2);
    wait_drain();
    push_exp(1'b0, 32'd3);
    send_beat(63'd5, 1'b1, 6'd1);
    wait_drain();
    // -100 + -28 = -128, shift 3 -> -16; shift changed mid-vector is ignored
    push_exp(1'b0, 32'hFFFF_FFF0);
    send_beat(-63'sd100, 1'b0, 6'd3);
    send_beat(-63'sd28, 1'b1, 6'd9);
    wait_drain();

    // saturation
    push_exp(1'b1, 32'h7FFF_FFFF);
    send_beat(63'h100_0000_0000, 1'b1, 6'd0);
    wait_drain();
    push_exp(1'b1, 32'h8000_0000);
    send_beat(-63'sh100_0000_0000, 1'b1, 6'd0);
    wait_drain();
    push_exp(1'b0, 32'h4000_0000);
    send_beat(63'h100_0000_0000, 1'b1, 6'd10);
    wait_drain();

    // backpressure
    bus.out_ready = 1'b0;
    push_exp(1'b0, 32'd77);
    send_beat(63'd77, 1'b1, 6'd0);
    budget = 0;
    while (!bus.out_valid && budget < 20) begin
      @(negedge ap_clk);
      budget++;
    end
    if (!bus.out_valid) fail_now("bp_out_valid");
    @(posedge ap_clk);
    #1;
    bus.in_data = 63'd999;
    bus.in_last = 1'b1;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge ap_clk);
      check("bp_in_ready", 64'(bus.in_ready), 64'd0);
      check("bp_out_valid", 64'(bus.out_valid), 64'd1);
    end
    @(posedge ap_clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge ap_clk);
    check("bp_transfer_valid", 64'(bus.out_valid), 64'd1);
    @(posedge ap_clk);
    #1;
    @(negedge ap_clk);
    check("bp_in_ready_after", 64'(bus.in_ready), 64'd1);
    check("bp_queue_empty", 64'(exp_q.size()), 64'd0);
    @(posedge ap_clk);
    #1;

    // reset mid-vector discards the partial sum
    send_beat(63'd100, 1'b0, 6'd0);
    send_beat(63'd200, 1'b0, 6'd0);
    @(negedge ap_clk);
    ap_rst_n = 1'b0;
    @(negedge ap_clk);
    check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    ap_rst_n = 1'b1;
    @(posedge ap_clk);
    #1;
    push_exp(1'b0, 32'd3);
    send_beat(63'd3, 1'b1, 6'd0);
    wait_drain();

    repeat (5) @(posedge ap_clk);
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
